// File: rtl/rom_reader_pkg.sv
// Shared phase codes and sizing helpers for the serial PROM reader.
// Phase codes are what the operation output shows to external shift registers and displays.
package rom_reader_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    PH_IDLE        = 4'h0,
    PH_SET_ADDRESS = 4'h1,
    PH_WAIT_ACCESS = 4'h2,
    PH_SAMPLE      = 4'h3,
    PH_SHIFT_DATA  = 4'h4,
    PH_DONE        = 4'h5
  } phase_t;

  localparam int CHIP_3601 = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rom_reader_if.sv
// Button, ROM data and serial output signals of the PROM reader, bundled for port hookup.
// No valid/ready handshake: buttons are level inputs, and the serial outputs are qualified by operation.
interface rom_reader_if #(
  parameter int DATA_WIDTH = 4
);
  import rom_reader_pkg::*;

  logic                  increment_address;
  logic                  decrement_address;
  logic [DATA_WIDTH-1:0] data_line_in;
  logic [OP_W-1:0]       operation;
  logic                  address_line;
  logic                  data_line;

  modport master (
    output increment_address,
    output decrement_address,
    output data_line_in,
    input  operation,
    input  address_line,
    input  data_line
  );

  modport slave (
    input  increment_address,
    input  decrement_address,
    input  data_line_in,
    output operation,
    output address_line,
    output data_line
  );

endinterface

// File: rtl/rom_reader_btn_sync.sv
// Two-flop synchronizer for an asynchronous button, followed by a rising-edge pulse.
// The pulse is formed from flopped values only, so it is a clean single-cycle strobe.
module rom_reader_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= button;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/rom_reader.sv
// Serial front end for parallel PROMs: holds an address steered by buttons and, on every
// address change, shifts the address out, waits the access time, samples and shifts the word out.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int SELECTED_CHIP = CHIP_3601
) (
  input  logic         clk,
  input  logic         reset_n,
  rom_reader_if.slave  bus
);

  localparam int CNT_MAX = max3(ADDRESS_WIDTH, DATA_WIDTH, ACCESS_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Data rotation below reads bit DW-2, so words narrower than two bits are not supported.
  if (ACCESS_CYCLES < 1 || DATA_WIDTH < 2 || ADDRESS_WIDTH < 1 || SELECTED_CHIP < 0) begin : g_bad_cfg
    $error("rom_reader: unsupported parameter set");
  end

  logic inc_pulse;
  logic dec_pulse;

  rom_reader_btn_sync u_inc_sync (
    .clk    (clk),
    .rst    (reset_n),
    .button (bus.increment_address),
    .pulse  (inc_pulse)
  );

  rom_reader_btn_sync u_dec_sync (
    .clk    (clk),
    .rst    (reset_n),
    .button (bus.decrement_address),
    .pulse  (dec_pulse)
  );

  phase_t                   state;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [ADDRESS_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0]    data_reg;
  logic [CW-1:0]            cnt;
  logic                     auto_read;
  logic                     address_line_q;
  logic                     data_line_q;

  logic                     start;
  logic [ADDRESS_WIDTH-1:0] next_address;

  // Simultaneous inc and dec edges cancel out and leave the reader idle.
  always_comb begin
    start        = 1'b0;
    next_address = address;
    if (auto_read) begin
      start = 1'b1;
    end else if (inc_pulse && !dec_pulse) begin
      start        = 1'b1;
      next_address = address + ADDRESS_WIDTH'(1);
    end else if (dec_pulse && !inc_pulse) begin
      start        = 1'b1;
      next_address = address - ADDRESS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state          <= PH_IDLE;
      address        <= '0;
      addr_sr        <= '0;
      data_reg       <= '0;
      cnt            <= '0;
      auto_read      <= 1'b1;
      address_line_q <= 1'b0;
      data_line_q    <= 1'b0;
    end else begin
      case (state)
        PH_IDLE: begin
          if (start) begin
            auto_read      <= 1'b0;
            address        <= next_address;
            addr_sr        <= next_address << 1;
            address_line_q <= next_address[ADDRESS_WIDTH-1];
            cnt            <= '0;
            state          <= PH_SET_ADDRESS;
          end
        end
        PH_SET_ADDRESS: begin
          if (cnt == CW'(ADDRESS_WIDTH - 1)) begin
            cnt            <= '0;
            address_line_q <= 1'b0;
            state          <= PH_WAIT_ACCESS;
          end else begin
            cnt            <= cnt + CW'(1);
            address_line_q <= addr_sr[ADDRESS_WIDTH-1];
            addr_sr        <= addr_sr << 1;
          end
        end
        PH_WAIT_ACCESS: begin
          if (cnt == CW'(ACCESS_CYCLES - 1)) begin
            cnt   <= '0;
            state <= PH_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PH_SAMPLE: begin
          data_reg    <= bus.data_line_in;
          data_line_q <= bus.data_line_in[DATA_WIDTH-1];
          cnt         <= '0;
          state       <= PH_SHIFT_DATA;
        end
        PH_SHIFT_DATA: begin
          // Rotating keeps the full sampled word in data_reg once the frame completes.
          data_reg <= {data_reg[DATA_WIDTH-2:0], data_reg[DATA_WIDTH-1]};
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            cnt         <= '0;
            data_line_q <= 1'b0;
            state       <= PH_DONE;
          end else begin
            cnt         <= cnt + CW'(1);
            data_line_q <= data_reg[DATA_WIDTH-2];
          end
        end
        PH_DONE: begin
          state <= PH_IDLE;
        end
        default: begin
          state <= PH_IDLE;
        end
      endcase
    end
  end

  assign bus.operation    = state;
  assign bus.address_line = address_line_q;
  assign bus.data_line    = data_line_q;

endmodule

// File: tb/tb_rom_reader.sv
// Directed-plus-random bench for rom_reader: each read frame is predicted from the address
// and data word with plain arithmetic and checked cycle by cycle from an expected queue.
module tb_rom_reader;

  localparam int DW = 4;
  localparam int AW = 8;
  localparam int AC = 2;

  logic clk;
  logic reset_n;

  rom_reader_if #(.DATA_WIDTH(DW)) bus ();

  rom_reader #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .ACCESS_CYCLES (AC),
    .SELECTED_CHIP (0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #100 clk = ~clk;

  initial begin
    #(200 * 20000);
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [5:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int inc_hold = 0;
  int dec_hold = 0;
  int ref_addr = 0;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the next sampling point, releasing buttons whose hold time has expired.
  task automatic tick();
    @(negedge clk);
    if (inc_hold > 0) begin
      inc_hold--;
      if (inc_hold == 0) bus.increment_address = 1'b0;
    end
    if (dec_hold > 0) begin
      dec_hold--;
      if (dec_hold == 0) bus.decrement_address = 1'b0;
    end
  endtask

  task automatic press_inc();
    bus.increment_address = 1'b1;
    inc_hold = 3;
  endtask

  task automatic press_dec();
    bus.decrement_address = 1'b1;
    dec_hold = 3;
  endtask

  // Frame model: AW address bits MSB first, AC waits, one sample, DW data bits, done, idle.
  task automatic build_frame(input int addr, input int data);
    exp_q.delete();
    for (int i = 0; i < AW; i++)
      exp_q.push_back({4'h1, 1'((addr >> (AW - 1 - i)) & 1), 1'b0});
    for (int i = 0; i < AC; i++)
      exp_q.push_back({4'h2, 2'b00});
    exp_q.push_back({4'h3, 2'b00});
    for (int i = 0; i < DW; i++)
      exp_q.push_back({4'h4, 1'b0, 1'((data >> (DW - 1 - i)) & 1)});
    exp_q.push_back({4'h5, 2'b00});
    exp_q.push_back({4'h0, 2'b00});
  endtask

  task automatic run_read(input string tag, input int addr, input int data,
                          input bit change_data, input int new_data, input bit press_mid);
    int waited;
    int idx;
    logic [5:0] exp;
    build_frame(addr, data);
    bus.data_line_in = DW'(data);
    waited = 0;
    while (bus.operation !== 4'h1 && waited < 12) begin
      tick();
      waited++;
    end
    check({tag, "_start"}, {2'b00, bus.operation}, 6'h01);
    idx = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, idx), {bus.operation, bus.address_line, bus.data_line}, exp);
      if (change_data && idx == 12) bus.data_line_in = DW'(new_data);
      if (press_mid && idx == 11) press_inc();
      idx++;
      tick();
    end
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check($sformatf("%s_%0d", tag, i), {bus.operation, bus.address_line, bus.data_line}, 6'h00);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dir;
    int d;
    bus.increment_address = 1'b0;
    bus.decrement_address = 1'b0;
    bus.data_line_in      = 4'hB;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    check("reset_state", {bus.operation, bus.address_line, bus.data_line}, 6'h00);

    // Power-up auto-read of address 0 with data B.
    @(negedge clk);
    reset_n = 1'b0;
    run_read("auto0", 0, 4'hB, 1'b0, 0, 1'b0);

    // Increment to 1, decrement back to 0, wrap below 0, and wrap above all ones.
    press_inc(); ref_addr = (ref_addr + 1) % (1 << AW);
    run_read("inc1", ref_addr, 4'h5, 1'b0, 0, 1'b0);
    press_dec(); ref_addr = (ref_addr + (1 << AW) - 1) % (1 << AW);
    run_read("dec0", ref_addr, 4'hA, 1'b0, 0, 1'b0);
    press_dec(); ref_addr = (ref_addr + (1 << AW) - 1) % (1 << AW);
    run_read("wrap_dn", ref_addr, 4'h3, 1'b0, 0, 1'b0);
    press_inc(); ref_addr = (ref_addr + 1) % (1 << AW);
    run_read("wrap_up", ref_addr, 4'hC, 1'b0, 0, 1'b0);

    // Simultaneous edges cancel; a press during SHIFT_DATA is discarded.
    press_inc();
    press_dec();
    expect_idle("both_btn", 8);
    press_inc(); ref_addr = (ref_addr + 1) % (1 << AW);
    run_read("mid_press", ref_addr, 4'h9, 1'b0, 0, 1'b1);
    expect_idle("after_mid", 8);

    // Data input changes after SAMPLE must not disturb the outgoing frame.
    press_inc(); ref_addr = (ref_addr + 1) % (1 << AW);
    run_read("hold_data", ref_addr, 4'hB, 1'b1, 4'h6, 1'b0);

    // Reset mid SET_ADDRESS clears outputs immediately, then auto-reads address 0.
    press_inc();
    for (int i = 0; i < 6 && bus.operation !== 4'h1; i++) tick();
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("mid_reset", {bus.operation, bus.address_line, bus.data_line}, 6'h00);
    tick();
    tick();
    reset_n = 1'b0;
    ref_addr = 0;
    run_read("post_reset", ref_addr, 4'h7, 1'b0, 0, 1'b0);

    // Random walk of the address with random ROM contents.
    for (int k = 0; k < 8; k++) begin
      dir = $urandom_range(0, 1);
      d   = $urandom_range(0, (1 << DW) - 1);
      if (dir == 1) begin
        press_inc(); ref_addr = (ref_addr + 1) % (1 << AW);
      end else begin
        press_dec(); ref_addr = (ref_addr + (1 << AW) - 1) % (1 << AW);
      end
      run_read($sformatf("rnd%0d", k), ref_addr, d, 1'b0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
